// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader state encoding and the byte/word geometry used by
// imem_loader and byte_packer. No ports.
package imem_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        LEN  = 2'd0,
        DATA = 2'd1,
        CHK  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word assembler for the instruction-memory loader.
// Collects BYTES_PER_WORD accepted bytes, first byte in the MSBs (big-endian).
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   accept       - a byte on data is taken this cycle
//   clear        - return the byte counter to zero (reload)
//   data         - stream byte
//   word         - assembled word, valid while word_valid is high
//   word_valid   - high in the cycle the last byte of a word is accepted
module byte_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic              clear,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [WORD_W-BYTE_W-1:0] sr_q, sr_d;

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clear) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
            sr_d  = {sr_q[WORD_W-2*BYTE_W-1:0], data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    // The final byte is used straight from the input so the loader can
    // register the complete word on the same edge that accepts it.
    assign word       = {sr_q, data};
    assign word_valid = accept && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: writer side of the CPU instruction memory.
// Receives a length word N followed by N big-endian data words over a byte
// valid/ready stream, writes them from BASE_ADDR upward and holds the CPU
// in stall until the image is complete.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect a trailing
// XOR checksum word after the data words.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   in_valid/in_ready/in_data - byte stream handshake
//   restart                 - reload request, honoured only in DONE
//   imem_we/addr/wdata      - instruction-memory write port
//   cpu_hold                - stall request to the CPU core
//   load_done               - one-cycle pulse when the load completes
//   load_err                - sticky error for the current load
//   words_loaded            - words actually written in the current load
//
// state | meaning
// LEN   | receiving the 4-byte word count
// DATA  | receiving data words, writing those that fit
// CHK   | receiving the checksum word (checksum build only)
// DONE  | image complete, CPU released, stream stalled
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [32:0] ROOM = 33'(DEPTH - BASE_ADDR);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   remaining_q, remaining_d;
    logic [ADDR_W:0]     wl_q, wl_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept, clear, word_valid, writable;
    logic [WORD_W-1:0]   word;
    logic [ADDR_W+1:0]   next_full;
    state_t              after_data;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]   csum_q, csum_d;
    assign after_data = CHK;
`else
    assign after_data = DONE;
`endif

    assign in_ready = (state_q != DONE);
    assign cpu_hold = (state_q != DONE);
    assign accept   = in_valid && in_ready;

    // Extra headroom bit so BASE_ADDR + count cannot wrap back into range.
    assign next_full = (ADDR_W+2)'(BASE_ADDR) + {1'b0, wl_q};
    assign writable  = next_full < (ADDR_W+2)'(DEPTH);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .accept     (accept),
        .clear      (clear),
        .data       (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wl_d        = wl_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        err_d       = err_q;
        clear       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            LEN: begin
                if (word_valid) begin
                    remaining_d = word;
                    if ({1'b0, word} > ROOM) err_d = 1'b1;
                    state_d = (word == '0) ? after_data : DATA;
                end
            end
            DATA: begin
                if (word_valid) begin
                    remaining_d = remaining_q - 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ word;
`endif
                    if (writable) begin
                        we_d    = 1'b1;
                        addr_d  = next_full[ADDR_W-1:0];
                        wdata_d = word;
                        wl_d    = wl_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (remaining_q == WORD_W'(1)) state_d = after_data;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (word_valid) begin
                    if (word != csum_q) err_d = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (restart) begin
                    state_d = LEN;
                    err_d   = 1'b0;
                    wl_d    = '0;
                    clear   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            default: state_d = LEN;
        endcase
        done_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LEN;
            remaining_q <= '0;
            wl_q        <= '0;
            addr_q      <= ADDR_W'(BASE_ADDR);
            wdata_q     <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wl_q        <= wl_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = wl_q;

endmodule
